cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 48 ++++
 rtl/cpu_ctrl_instr_dec.sv | 41 ++++
 rtl/cpu_ctrl.sv | 145 ++++++++++++++
 tb/tb_cpu_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: FSM state encoding, opcode/op constants, vsel codes
// and the decoded operation classes shared by cpu_ctrl and instr_dec.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_WAIT,
      S_DECODE,
      S_WRITE_IMM,
      S_GET_A,
      S_GET_B,
      S_ALU,
      S_WRITE_REG
   } state_t;

   typedef enum logic [2:0] {
      C_ILL,
      C_MOVI,
      C_MOVR,
      C_MVN,
      C_ADD,
      C_CMP,
      C_AND
   } op_class_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOVI = 2'b10;
   localparam logic [1:0] OP_MOVR = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_CMP  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_MVN  = 2'b11;

   localparam logic [3:0] VSEL_C     = 4'b0001;
   localparam logic [3:0] VSEL_PC    = 4'b0010;
   localparam logic [3:0] VSEL_IMM   = 4'b0100;
   localparam logic [3:0] VSEL_MDATA = 4'b1000;

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

   function automatic logic [15:0] sext5(input logic [4:0] v);
      return {{11{v[4]}}, v};
   endfunction

endpackage

// File: rtl/cpu_ctrl_instr_dec.sv
// instr_dec: splits the IR into fields, sign-extends the immediates
// and classifies opcode/op. Ports: ir in; rn, rd, rm, sh, op, sximm5, sximm8, cls out.
module instr_dec
   import cpu_ctrl_pkg::*;
(
   input  logic [15:0] ir,
   output logic [1:0]  op,
   output logic [2:0]  rn,
   output logic [2:0]  rd,
   output logic [1:0]  sh,
   output logic [2:0]  rm,
   output logic [15:0] sximm5,
   output logic [15:0] sximm8,
   output op_class_t   cls
);

   logic [2:0] opc;

   assign opc    = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];
   assign sximm8 = sext8(ir[7:0]);
   assign sximm5 = sext5(ir[4:0]);

   always_comb begin
      cls = C_ILL;
      unique case (1'b1)
         (opc == OPC_MOV) && (op == OP_MOVI): cls = C_MOVI;
         (opc == OPC_MOV) && (op == OP_MOVR): cls = C_MOVR;
         (opc == OPC_ALU) && (op == OP_MVN):  cls = C_MVN;
         (opc == OPC_ALU) && (op == OP_ADD):  cls = C_ADD;
         (opc == OPC_ALU) && (op == OP_CMP):  cls = C_CMP;
         (opc == OPC_ALU) && (op == OP_AND):  cls = C_AND;
         default:                             cls = C_ILL;
      endcase
   end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction register plus Moore FSM driving datapath strobes.
// Ports: clk, reset_n, in, load, s -> w, readnum, writenum, vsel, strobes,
// shift, ALUop, sximm8, sximm5; ill only when CPU_CTRL_ILLEGAL_EN is defined.
module cpu_ctrl
   import cpu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic [3:0]  vsel,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic        loadc,
   output logic        loads,
   output logic        write,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
`ifdef CPU_CTRL_ILLEGAL_EN
   output logic        ill,
`endif
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   state_t    state, nxt;
   logic [15:0] ir;
   logic [1:0]  op;
   logic [2:0]  rn, rd, rm;
   logic [1:0]  sh;
   op_class_t   cls;

   instr_dec u_dec (
      .ir     (ir),
      .op     (op),
      .rn     (rn),
      .rd     (rd),
      .sh     (sh),
      .rm     (rm),
      .sximm5 (sximm5),
      .sximm8 (sximm8),
      .cls    (cls)
   );

   // IR only accepts a new word while idle; DECODE then sees it
   // on the same edge that samples s.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ir <= '0;
      else if (load && state == S_WAIT)
         ir <= in;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= S_WAIT;
      else
         state <= nxt;
   end

`ifdef CPU_CTRL_ILLEGAL_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ill <= 1'b0;
      else if (state == S_WAIT && s)
         ill <= 1'b0;
      else if (state == S_DECODE && cls == C_ILL)
         ill <= 1'b1;
   end
`endif

   always_comb begin
      nxt      = state;
      w        = 1'b0;
      readnum  = 3'd0;
      writenum = 3'd0;
      vsel     = 4'd0;
      loada    = 1'b0;
      loadb    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      write    = 1'b0;
      shift    = 2'd0;
      ALUop    = 2'd0;
      unique case (state)
         S_WAIT: begin
            w = 1'b1;
            if (s) nxt = S_DECODE;
         end
         S_DECODE: begin
            unique case (cls)
               C_MOVI:              nxt = S_WRITE_IMM;
               C_MOVR, C_MVN:       nxt = S_GET_B;
               C_ADD, C_CMP, C_AND: nxt = S_GET_A;
               default:             nxt = S_WAIT;
            endcase
         end
         S_WRITE_IMM: begin
            writenum = rn;
            vsel     = VSEL_IMM;
            write    = 1'b1;
            nxt      = S_WAIT;
         end
         S_GET_A: begin
            readnum = rn;
            loada   = 1'b1;
            nxt     = S_GET_B;
         end
         S_GET_B: begin
            readnum = rm;
            loadb   = 1'b1;
            nxt     = S_ALU;
         end
         S_ALU: begin
            shift = sh;
            ALUop = (cls == C_MOVR) ? 2'b00 : op;
            // Moves pass B through with A forced to zero.
            asel  = (cls == C_MOVR) || (cls == C_MVN);
            if (cls == C_CMP) begin
               loads = 1'b1;
               nxt   = S_WAIT;
            end else begin
               loadc = 1'b1;
               nxt   = S_WRITE_REG;
            end
         end
         S_WRITE_REG: begin
            writenum = rd;
            vsel     = VSEL_C;
            write    = 1'b1;
            nxt      = S_WAIT;
         end
         default: nxt = S_WAIT;
      endcase
   end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed scoreboard bench for cpu_ctrl; expected
// per-cycle outputs are queued with each instruction and popped per edge.
module tb_cpu_ctrl;

   typedef struct packed {
      logic       w;
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic [3:0] vsel;
      logic       loada;
      logic       loadb;
      logic       asel;
      logic       bsel;
      logic       loadc;
      logic       loads;
      logic       write;
      logic [1:0] shift;
      logic [1:0] aluop;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] in;
   logic        load, s;
   logic        w, loada, loadb, asel, bsel, loadc, loads, write;
   logic [2:0]  readnum, writenum;
   logic [3:0]  vsel;
   logic [1:0]  shift, ALUop;
   logic [15:0] sximm8, sximm5;
`ifdef CPU_CTRL_ILLEGAL_EN
   logic        ill;
`endif

   int nchk  = 0;
   int nfail = 0;
   obs_t sb[$];

   always #5 clk = ~clk;

   cpu_ctrl dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in       (in),
      .load     (load),
      .s        (s),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .vsel     (vsel),
      .loada    (loada),
      .loadb    (loadb),
      .asel     (asel),
      .bsel     (bsel),
      .loadc    (loadc),
      .loads    (loads),
      .write    (write),
      .shift    (shift),
      .ALUop    (ALUop),
`ifdef CPU_CTRL_ILLEGAL_EN
      .ill      (ill),
`endif
      .sximm8   (sximm8),
      .sximm5   (sximm5)
   );

   function automatic obs_t cur();
      return '{w, readnum, writenum, vsel, loada, loadb, asel, bsel,
               loadc, loads, write, shift, ALUop};
   endfunction

   function automatic obs_t o_wait();
      obs_t o = '0;
      o.w = 1'b1;
      return o;
   endfunction

   function automatic obs_t o_dec();
      return '0;
   endfunction

   function automatic obs_t o_wimm(input logic [2:0] n);
      obs_t o = '0;
      o.writenum = n;
      o.vsel = 4'b0100;
      o.write = 1'b1;
      return o;
   endfunction

   function automatic obs_t o_geta(input logic [2:0] n);
      obs_t o = '0;
      o.readnum = n;
      o.loada = 1'b1;
      return o;
   endfunction

   function automatic obs_t o_getb(input logic [2:0] n);
      obs_t o = '0;
      o.readnum = n;
      o.loadb = 1'b1;
      return o;
   endfunction

   function automatic obs_t o_alu(input logic a, input logic [1:0] sh,
                                  input logic [1:0] op, input logic cmp);
      obs_t o = '0;
      o.asel = a;
      o.shift = sh;
      o.aluop = op;
      o.loadc = !cmp;
      o.loads = cmp;
      return o;
   endfunction

   function automatic obs_t o_wreg(input logic [2:0] n);
      obs_t o = '0;
      o.writenum = n;
      o.vsel = 4'b0001;
      o.write = 1'b1;
      return o;
   endfunction

   task automatic chk_o(input obs_t a, input obs_t e, input string tag);
      nchk++;
      assert (a === e) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, a, e);
      end
   endtask

   task automatic chk_v(input logic [31:0] a, input logic [31:0] e,
                        input string tag);
      nchk++;
      assert (a === e) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, a, e);
      end
   endtask

   // Issue one instruction with load+s together, then walk the queued
   // expectations one edge at a time. Optionally hammers load with a
   // junk word while the instruction is in flight.
   task automatic run(input logic [15:0] instr, input int lat,
                      input logic [15:0] x8, input string tag,
                      input bit junk);
      obs_t a, e;
      int k, seen;
      in = instr; load = 1'b1; s = 1'b1;
      @(posedge clk); #1;
      s = 1'b0; load = 1'b0;
      if (junk) begin in = 16'h00FF; load = 1'b1; end
      k = 0; seen = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         k++;
         a = cur();
         chk_o(a, e, $sformatf("%s_c%0d", tag, k));
         if (a.w && seen == 0) seen = k;
         if (sb.size() > 0) begin @(posedge clk); #1; end
      end
      load = 1'b0;
      chk_v(seen, lat, {tag, "_lat"});
      chk_v({16'd0, sximm8}, {16'd0, x8}, {tag, "_imm8"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; in = '0; load = 1'b0; s = 1'b0;
      #1;
      chk_o(cur(), o_wait(), "reset_outs");
      chk_v({16'd0, sximm8}, 32'd0, "reset_ir");
      @(negedge clk); reset_n = 1'b1;

      // Idle: no s keeps WAIT; load alone updates IR.
      in = 16'h0080; load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      chk_o(cur(), o_wait(), "idle_wait");
      chk_v({16'd0, sximm8}, 32'h0000FF80, "idle_load");

      // MOV R0,#7
      sb.push_back(o_dec()); sb.push_back(o_wimm(3'd0));
      sb.push_back(o_wait());
      run(16'hD007, 3, 16'h0007, "mov_r0_7", 1'b0);

      // MOV R1,#-2
      sb.push_back(o_dec()); sb.push_back(o_wimm(3'd1));
      sb.push_back(o_wait());
      run(16'hD1FE, 3, 16'hFFFE, "mov_r1_m2", 1'b0);

      // ADD R2,R1,R0,LSL#1 with junk load held during execution
      sb.push_back(o_dec()); sb.push_back(o_geta(3'd1));
      sb.push_back(o_getb(3'd0));
      sb.push_back(o_alu(1'b0, 2'b01, 2'b00, 1'b0));
      sb.push_back(o_wreg(3'd2)); sb.push_back(o_wait());
      run(16'hA148, 6, 16'h0048, "add", 1'b1);
      chk_v({16'd0, sximm5}, 32'h00000008, "add_imm5");

      // CMP R1,R0
      sb.push_back(o_dec()); sb.push_back(o_geta(3'd1));
      sb.push_back(o_getb(3'd0));
      sb.push_back(o_alu(1'b0, 2'b00, 2'b01, 1'b1));
      sb.push_back(o_wait());
      run(16'hA900, 5, 16'h0000, "cmp", 1'b0);

      // MVN R3,R5,LSR
      sb.push_back(o_dec()); sb.push_back(o_getb(3'd5));
      sb.push_back(o_alu(1'b1, 2'b10, 2'b11, 1'b0));
      sb.push_back(o_wreg(3'd3)); sb.push_back(o_wait());
      run(16'hB875, 5, 16'h0075, "mvn", 1'b0);

      // MOV R4,R6
      sb.push_back(o_dec()); sb.push_back(o_getb(3'd6));
      sb.push_back(o_alu(1'b1, 2'b00, 2'b00, 1'b0));
      sb.push_back(o_wreg(3'd4)); sb.push_back(o_wait());
      run(16'hC086, 5, 16'hFF86, "movr", 1'b0);

      // AND R7,R2,R1,ASR
      sb.push_back(o_dec()); sb.push_back(o_geta(3'd2));
      sb.push_back(o_getb(3'd1));
      sb.push_back(o_alu(1'b0, 2'b11, 2'b10, 1'b0));
      sb.push_back(o_wreg(3'd7)); sb.push_back(o_wait());
      run(16'hB2F9, 6, 16'hFFF9, "and", 1'b0);
      chk_v({16'd0, sximm5}, 32'h0000FFF9, "and_imm5");

      // Illegal opcode
      sb.push_back(o_dec()); sb.push_back(o_wait());
      run(16'hE000, 2, 16'h0000, "illegal", 1'b0);
`ifdef CPU_CTRL_ILLEGAL_EN
      chk_v({31'd0, ill}, 32'd1, "ill_set");
`endif

      // Next instruction clears ill on its start
      sb.push_back(o_dec()); sb.push_back(o_wimm(3'd1));
      sb.push_back(o_wait());
      run(16'hD1FE, 3, 16'hFFFE, "after_ill", 1'b0);
`ifdef CPU_CTRL_ILLEGAL_EN
      chk_v({31'd0, ill}, 32'd0, "ill_clr");
`endif

      // Reset asserted while in GET_B, between clock edges
      in = 16'hA148; load = 1'b1; s = 1'b1;
      @(posedge clk); #1;
      s = 1'b0; load = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_o(cur(), o_getb(3'd0), "mid_getb");
      #2 reset_n = 1'b0;
      #1;
      chk_o(cur(), o_wait(), "mid_reset_outs");
      chk_v({16'd0, sximm8}, 32'd0, "mid_reset_ir");
      @(negedge clk); reset_n = 1'b1;

      // s honoured on the first edge after release
      sb.push_back(o_dec()); sb.push_back(o_wimm(3'd0));
      sb.push_back(o_wait());
      run(16'hD007, 3, 16'h0007, "post_reset", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
